fetch_redirect_ctrl: RTL
========================

Name: fetch_redirect_ctrl

Overview:
- Arbitrates every fetch-redirect source for the dual-issue front end and tells the PC register which target to load: trap (M), branch mispredict (E/M), unconditional jump (D), predicted-taken branch (D).
- Guarantees that no single-cycle redirect strobe is lost while stallF holds the PC.
- Enforces MIPS delay-slot ordering for D-stage redirects.
- Sits between the hazard/branch units and the PC register; the PC register uses redirect_valid/redirect_target in place of its sequential PC+8.

Parameters:
- AW, 32, address width of all targets.
- DS_WAIT_EN, 1, 1 = honour delay-slot wait for D-stage redirects; 0 = apply them immediately.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- stallF  in  1  PC hold this cycle; the PC loads nothing
- trap_req  in  1  exception redirect strobe (priority 3)
- trap_target  in  AW  exception vector
- mispred_req  in  1  mispredict redirect strobe (priority 2)
- mispred_target  in  AW  corrected PC (branch target or PC+8 of the branch)
- jump_req  in  1  D-stage jump strobe (priority 1)
- jump_target  in  AW  jump target
- bpred_req  in  1  D-stage predicted-taken strobe (priority 0)
- bpred_target  in  AW  predicted target
- ds_fetched  in  1  delay slot of the D-stage CTI is already fetched (same or earlier group)
- redirect_valid  out  1  PC register loads redirect_target this cycle (qualified by ~stallF)
- redirect_target  out  AW  target to load
- redirect_src  out  2  priority code of the applied source
- flush_f  out  1  kill the fetched group
- flush_d  out  1  kill the decode group
- busy  out  1  pending or WAIT_DS entry held

Behaviour:
- Storage:
  - Pending entry: pvalid, pprio[1:0], ptarget.
  - FSM: IDLE, HOLD (pending redirect, waiting for ~stallF), WAIT_DS (D-stage redirect waiting for delay-slot fetch).
  - ds_adv flag: the sequential advance past the delay slot has happened.
- Candidate each cycle: highest priority among the live strobes and the pending entry. On a priority tie between a live strobe and pending, pending (older) wins.
- Outputs are combinational from the candidate and state; state updates on posedge clk.
- IDLE, candidate prio>=2:
  - ~stallF: redirect_valid=1, flush_f=flush_d=1.
  - stallF: capture into pending, go to HOLD; all outputs 0.
- IDLE, candidate prio<=1:
  - ds_fetched=1 or DS_WAIT_EN=0: apply as above if ~stallF, but flush_f=1 and flush_d=0. If stallF, capture and go to HOLD.
  - ds_fetched=0: capture, go to WAIT_DS, ds_adv=~stallF, redirect_valid=0 (the PC advances sequentially to fetch the delay slot).
- HOLD:
  - A live strobe of strictly higher priority replaces pending.
  - On the first ~stallF cycle, apply pending (flushes per its priority), clear pvalid, return to IDLE.
- WAIT_DS:
  - Each ~stallF cycle with ds_adv=0 sets ds_adv=1, with no redirect.
  - The first ~stallF cycle with ds_adv=1 applies pending (flush_f=1 only), then returns to IDLE.
  - A prio>=2 strobe in WAIT_DS discards the D-stage entry. It applies immediately if ~stallF, else it is captured and the FSM goes to HOLD.
  - A prio<=1 strobe in WAIT_DS or HOLD is ignored; upstream stalls D until busy=0.
- A redirect is applied only when ~stallF. Exactly one redirect is applied per captured entry; pending never applies twice.
- busy=pvalid.
- Reset (any state, mid-wait included): pvalid=0, pprio=0, ptarget=0, ds_adv=0, FSM=IDLE; all outputs 0 during the rst cycle. Strobes present during rst are dropped.
- Simultaneous trap+mispred+jump: trap wins; the others are discarded, not queued.

Test Plan:
- IDLE, stallF=0, mispred_req=1, target 0x8000_0100 -> same cycle redirect_valid=1, target 0x8000_0100, src=2, flush_f=flush_d=1; next cycle all 0.
- stallF=1 for 3 cycles; jump_req pulse (ds_fetched=1, 0x8000_0200) in cycle 0; trap_req pulse (0xBFC0_0380) in cycle 1 -> no redirect while stalled, busy=1; first unstalled cycle redirect_valid=1, target 0xBFC0_0380, src=3; jump never applied.
- bpred_req with ds_fetched=0, stallF=0, target 0x8000_0400 -> redirect_valid=0 that cycle, FSM=WAIT_DS; next cycle redirect_valid=1, target 0x8000_0400, flush_f=1, flush_d=0.
- Same as previous, but mispred_req (0x8000_0010) arrives in the WAIT_DS cycle -> mispredict applied with src=2; the D-stage target is never output; busy=0 afterwards.
- rst asserted while in HOLD with pending 0x8000_0500 -> after rst: busy=0, FSM=IDLE, no redirect on the next unstalled cycle.
- jump_req and bpred_req in the same cycle, ds_fetched=1, unstalled -> jump_target applied, src=1.

Source files
------------

// File: rtl/fetch_redirect_ctrl.sv
// fetch_redirect_ctrl: picks the fetch-redirect source for the PC register.
// Sources, from highest priority: trap (3), mispredict (2), jump (1), and
// predicted-taken branch (0). A strobe that arrives while stallF is high is
// held in a single pending entry. D-stage redirects can also wait until the
// delay slot has been fetched.
module fetch_redirect_ctrl #(
  parameter int AW         = 32,
  parameter bit DS_WAIT_EN = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stallF,
  input  logic          trap_req,
  input  logic [AW-1:0] trap_target,
  input  logic          mispred_req,
  input  logic [AW-1:0] mispred_target,
  input  logic          jump_req,
  input  logic [AW-1:0] jump_target,
  input  logic          bpred_req,
  input  logic [AW-1:0] bpred_target,
  input  logic          ds_fetched,
  output logic          redirect_valid,
  output logic [AW-1:0] redirect_target,
  output logic [1:0]    redirect_src,
  output logic          flush_f,
  output logic          flush_d,
  output logic          busy
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_HOLD    = 2'd1;
  localparam logic [1:0] S_WAIT_DS = 2'd2;

  logic [1:0]    state_reg, state_next;
  logic          pvalid_reg, pvalid_next;
  logic [1:0]    pprio_reg, pprio_next;
  logic [AW-1:0] ptarget_reg, ptarget_next;
  logic          ds_adv_reg, ds_adv_next;

  logic          live_v;
  logic [1:0]    live_prio;
  logic [AW-1:0] live_tgt;
  logic [1:0]    hold_prio;
  logic [AW-1:0] hold_tgt;

  logic          apply_c, flush_d_c;
  logic [1:0]    src_c;
  logic [AW-1:0] tgt_c;

  // Fixed-priority encode of the live strobes. Strobes that lose are dropped.
  always_comb begin
    live_v    = 1'b1;
    live_prio = 2'd0;
    live_tgt  = bpred_target;
    if (trap_req) begin
      live_prio = 2'd3;
      live_tgt  = trap_target;
    end else if (mispred_req) begin
      live_prio = 2'd2;
      live_tgt  = mispred_target;
    end else if (jump_req) begin
      live_prio = 2'd1;
      live_tgt  = jump_target;
    end else if (!bpred_req) begin
      live_v    = 1'b0;
    end
  end

  // In HOLD, only a strictly higher M/E-stage strobe replaces the older entry.
  // On a priority tie, the pending entry wins.
  always_comb begin
    hold_prio = pprio_reg;
    hold_tgt  = ptarget_reg;
    if (live_v && live_prio[1] && (live_prio > pprio_reg)) begin
      hold_prio = live_prio;
      hold_tgt  = live_tgt;
    end
  end

  // Next-state logic, and the redirect to apply in this cycle.
  always_comb begin
    state_next   = state_reg;
    pvalid_next  = pvalid_reg;
    pprio_next   = pprio_reg;
    ptarget_next = ptarget_reg;
    ds_adv_next  = ds_adv_reg;
    apply_c      = 1'b0;
    flush_d_c    = 1'b0;
    src_c        = 2'd0;
    tgt_c        = '0;
    case (state_reg)
      S_IDLE: begin
        if (live_v) begin
          if (live_prio[1] || ds_fetched || !DS_WAIT_EN) begin
            if (!stallF) begin
              apply_c   = 1'b1;
              src_c     = live_prio;
              tgt_c     = live_tgt;
              flush_d_c = live_prio[1];
            end else begin
              state_next   = S_HOLD;
              pvalid_next  = 1'b1;
              pprio_next   = live_prio;
              ptarget_next = live_tgt;
            end
          end else begin
            // Delay slot not fetched yet: let the PC advance sequentially first.
            state_next   = S_WAIT_DS;
            pvalid_next  = 1'b1;
            pprio_next   = live_prio;
            ptarget_next = live_tgt;
            ds_adv_next  = !stallF;
          end
        end
      end
      S_HOLD: begin
        if (!stallF) begin
          apply_c      = 1'b1;
          src_c        = hold_prio;
          tgt_c        = hold_tgt;
          flush_d_c    = hold_prio[1];
          state_next   = S_IDLE;
          pvalid_next  = 1'b0;
          pprio_next   = 2'd0;
          ptarget_next = '0;
        end else begin
          pprio_next   = hold_prio;
          ptarget_next = hold_tgt;
        end
      end
      S_WAIT_DS: begin
        if (live_v && live_prio[1]) begin
          // A later-stage redirect makes the D-stage entry obsolete.
          ds_adv_next = 1'b0;
          if (!stallF) begin
            apply_c      = 1'b1;
            src_c        = live_prio;
            tgt_c        = live_tgt;
            flush_d_c    = 1'b1;
            state_next   = S_IDLE;
            pvalid_next  = 1'b0;
            pprio_next   = 2'd0;
            ptarget_next = '0;
          end else begin
            state_next   = S_HOLD;
            pprio_next   = live_prio;
            ptarget_next = live_tgt;
          end
        end else if (!stallF) begin
          if (ds_adv_reg) begin
            apply_c      = 1'b1;
            src_c        = pprio_reg;
            tgt_c        = ptarget_reg;
            state_next   = S_IDLE;
            pvalid_next  = 1'b0;
            pprio_next   = 2'd0;
            ptarget_next = '0;
            ds_adv_next  = 1'b0;
          end else begin
            ds_adv_next = 1'b1;
          end
        end
      end
      default: begin
        state_next  = S_IDLE;
        pvalid_next = 1'b0;
        ds_adv_next = 1'b0;
      end
    endcase
  end

  // State registers. Reset also drops any strobe present in the reset cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      pvalid_reg  <= 1'b0;
      pprio_reg   <= 2'd0;
      ptarget_reg <= '0;
      ds_adv_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pvalid_reg  <= pvalid_next;
      pprio_reg   <= pprio_next;
      ptarget_reg <= ptarget_next;
      ds_adv_reg  <= ds_adv_next;
    end
  end

  assign redirect_valid  = apply_c & ~rst;
  assign redirect_target = redirect_valid ? tgt_c : '0;
  assign redirect_src    = redirect_valid ? src_c : 2'd0;
  assign flush_f         = redirect_valid;
  assign flush_d         = redirect_valid & flush_d_c;
  assign busy            = pvalid_reg & ~rst;

endmodule
